// File: rtl/ram_responder.sv
// Word-addressed 64-bit RAM responder with a post-reset clearing sweep and registered reads.
// Optional macro RAM_FWD_EN: same-cycle read/write of one word returns the merged write value.
module ram_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RamReadEnable,
  input  logic [63:0] RamReadAddr,
  output logic [63:0] RamReadData,
  input  logic        RamWriteEnable,
  input  logic [63:0] RamWriteAddr,
  input  logic [63:0] RamWriteMask,
  input  logic [63:0] RamWriteData,
  output logic        ready,
  output logic        err
);

  typedef enum logic {CLEAR, RUN} stateT;

  stateT                 state;
  logic [DEPTH_LOG2-1:0] clearCount;
  logic [63:0]           mem [1 << DEPTH_LOG2];

  logic [63:0]           readOffset;
  logic [63:0]           writeOffset;
  logic                  readInRange;
  logic                  writeInRange;
  logic [DEPTH_LOG2-1:0] readIndex;
  logic [DEPTH_LOG2-1:0] writeIndex;
  logic                  writeHit;
  logic [63:0]           writeMerged;
  logic [63:0]           readWord;
  logic                  unusedAddrBits;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range naturally.
  assign readOffset     = RamReadAddr - BASE_ADDR;
  assign writeOffset    = RamWriteAddr - BASE_ADDR;
  assign readInRange    = (readOffset[63:DEPTH_LOG2+3] == '0);
  assign writeInRange   = (writeOffset[63:DEPTH_LOG2+3] == '0);
  assign readIndex      = readOffset[DEPTH_LOG2+2:3];
  assign writeIndex     = writeOffset[DEPTH_LOG2+2:3];
  assign unusedAddrBits = ^{readOffset[2:0], writeOffset[2:0]};

  assign writeHit    = (state == RUN) && RamWriteEnable && writeInRange;
  assign writeMerged = (mem[writeIndex] & ~RamWriteMask) | (RamWriteData & RamWriteMask);

`ifdef RAM_FWD_EN
  assign readWord = (writeHit && (writeIndex == readIndex)) ? writeMerged : mem[readIndex];
`else
  assign readWord = mem[readIndex];
`endif

  // NOTE: the array has no reset branch; resetting every word would kill RAM inference,
  // so the CLEAR sweep zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clearCount] <= '0;
    end else if (writeHit) begin
      mem[writeIndex] <= writeMerged;
    end
  end

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      clearCount  <= '0;
      ready       <= 1'b0;
      err         <= 1'b0;
      RamReadData <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          RamReadData <= '0;
          clearCount  <= clearCount + 1'b1;
          if (clearCount == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (RamReadEnable) begin
            if (readInRange) begin
              RamReadData <= readWord;
            end else begin
              RamReadData <= '0;
              err         <= 1'b1;
            end
          end
          if (RamWriteEnable && !writeInRange) begin
            err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed scenarios plus random traffic
// checked against an array-based reference model of the memory.
module tb_ram_responder;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RamReadEnable = 1'b0;
  logic [63:0] RamReadAddr = '0;
  logic [63:0] RamReadData;
  logic        RamWriteEnable = 1'b0;
  logic [63:0] RamWriteAddr = '0;
  logic [63:0] RamWriteMask = '0;
  logic [63:0] RamWriteData = '0;
  logic        ready;
  logic        err;

  int nChecks = 0;
  int nFails  = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] expData;
  logic        expErr;

  ram_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .RamReadEnable (RamReadEnable),
    .RamReadAddr   (RamReadAddr),
    .RamReadData   (RamReadData),
    .RamWriteEnable(RamWriteEnable),
    .RamWriteAddr  (RamWriteAddr),
    .RamWriteMask  (RamWriteMask),
    .RamWriteData  (RamWriteData),
    .ready         (ready),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit inRange(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return (off >> 3) < 64'(DEPTH);
  endfunction

  function automatic int wordOf(input logic [63:0] a);
    logic [63:0] off;
    off = (a - BASE) >> 3;
    return int'(off[11:0]);
  endfunction

  // One RUN-mode cycle: drive a request pair, then compare against the model.
  task automatic step(input bit re, input logic [63:0] ra, input bit we,
                      input logic [63:0] wa, input logic [63:0] wm, input logic [63:0] wd);
    RamReadEnable  = re;
    RamReadAddr    = ra;
    RamWriteEnable = we;
    RamWriteAddr   = wa;
    RamWriteMask   = wm;
    RamWriteData   = wd;
    @(posedge clk);
    #1;
    if (re) begin
      if (inRange(ra)) begin
        expData = model[wordOf(ra)];
`ifdef RAM_FWD_EN
        if (we && inRange(wa) && wordOf(wa) == wordOf(ra))
          expData = (expData & ~wm) | (wd & wm);
`endif
      end else begin
        expData = '0;
        expErr  = 1'b1;
      end
    end
    if (we) begin
      if (inRange(wa)) model[wordOf(wa)] = (model[wordOf(wa)] & ~wm) | (wd & wm);
      else expErr = 1'b1;
    end
    RamReadEnable  = 1'b0;
    RamWriteEnable = 1'b0;
    check("readData", RamReadData, expData);
    check("err", {63'd0, err}, {63'd0, expErr});
    check("readyRun", {63'd0, ready}, 64'd1);
  endtask

  // Clocks the sweep with random ignored traffic until ready rises or maxEdges pass.
  task automatic runSweep(input int maxEdges, output int edges);
    edges = 0;
    while (edges < maxEdges) begin
      RamReadEnable  = 1'($urandom_range(0, 1));
      RamReadAddr    = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8;
      RamWriteEnable = 1'($urandom_range(0, 1));
      RamWriteAddr   = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8;
      RamWriteMask   = ONES;
      RamWriteData   = {$urandom, $urandom} | 64'd1;
      @(posedge clk);
      #1;
      edges++;
      check("sweepReadData", RamReadData, 64'd0);
      check("sweepErr", {63'd0, err}, 64'd0);
      if (ready) break;
    end
    RamReadEnable  = 1'b0;
    RamWriteEnable = 1'b0;
  endtask

  task automatic holdReset(input int cycles);
    rst = 1'b1;
    RamReadEnable  = 1'b0;
    RamWriteEnable = 1'b0;
    #1;
    check("rstReadyAsync", {63'd0, ready}, 64'd0);
    check("rstErrAsync", {63'd0, err}, 64'd0);
    check("rstDataAsync", RamReadData, 64'd0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    expData = '0;
    expErr  = 1'b0;
  endtask

  function automatic logic [63:0] randAddr();
    int w;
    w = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(DEPTH - 8, DEPTH - 1));
    return BASE + 64'(w) * 8 + 64'($urandom_range(0, 7));
  endfunction

  initial begin
    int edges;

    // Reset sweep
    @(posedge clk);
    holdReset(3);
    runSweep(5000, edges);
    check("sweepEdges", 64'(edges), 64'(DEPTH));
    check("sweepReady", {63'd0, ready}, 64'd1);
    step(1, BASE, 0, '0, '0, '0);
    check("word0AfterSweep", RamReadData, 64'd0);

    // Full write then read next cycle
    step(0, '0, 1, BASE + 64'h10, ONES, 64'h1122334455667788);
    step(1, BASE + 64'h10, 0, '0, '0, '0);
    check("fullWrite", RamReadData, 64'h1122334455667788);

    // Masked write; low address bits must be ignored
    step(0, '0, 1, BASE + 64'h13, 64'h0000_0000_FFFF_0000, ONES);
    step(1, BASE + 64'h17, 0, '0, '0, '0);
    check("maskedWrite", RamReadData, 64'h11223344FFFF7788);

    // Idle read cycle holds data
    step(0, BASE, 0, '0, '0, '0);
    check("holdData", RamReadData, 64'h11223344FFFF7788);

    // Same-cycle read and write to one word
    step(0, '0, 1, BASE + 64'h20, ONES, 64'hA);
    step(1, BASE + 64'h20, 1, BASE + 64'h20, ONES, 64'hB);
`ifdef RAM_FWD_EN
    check("sameCycleFwd", RamReadData, 64'hB);
`else
    check("sameCycleOld", RamReadData, 64'hA);
`endif
    step(1, BASE + 64'h20, 0, '0, '0, '0);
    check("sameCycleNext", RamReadData, 64'hB);

    // Simultaneous read and write to different words, last word boundary
    step(1, BASE + 64'h10, 1, BASE + 64'h7FF8, ONES, 64'hCAFE_F00D_0000_4095);
    check("diffWordsRead", RamReadData, 64'h11223344FFFF7788);
    step(1, BASE + 64'h7FFF, 0, '0, '0, '0);
    check("lastWord", RamReadData, 64'hCAFE_F00D_0000_4095);

    // Random in-range traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), randAddr(), 1'($urandom_range(0, 1)), randAddr(),
           {$urandom, $urandom}, {$urandom, $urandom});
    end
    check("noErrInRange", {63'd0, err}, 64'd0);

    // Out-of-range read below base, then write one past the end
    step(1, 64'h7FFF_FFF8, 0, '0, '0, '0);
    check("oorReadData", RamReadData, 64'd0);
    check("oorReadErr", {63'd0, err}, 64'd1);
    step(0, '0, 1, 64'h8000_8000, ONES, ONES);
    step(1, BASE, 0, '0, '0, '0);
    step(1, BASE + 64'h7FF8, 0, '0, '0, '0);
    check("errSticky", {63'd0, err}, 64'd1);

    // Reset mid-sweep: earlier data must be cleared and the sweep restarts
    step(0, '0, 1, BASE + 64'h28, ONES, 64'hDEAD_BEEF);
    holdReset(2);
    runSweep(2000, edges);
    check("midSweepNotReady", {63'd0, ready}, 64'd0);
    holdReset(2);
    runSweep(5000, edges);
    check("restartEdges", 64'(edges), 64'(DEPTH));
    step(1, BASE + 64'h28, 0, '0, '0, '0);
    check("clearedAfterReset", RamReadData, 64'd0);
    step(1, BASE + 64'h10, 0, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the core's unified instruction/data RAM interface. It accepts read and write requests from the core, holds a word-addressed 64-bit memory array, and returns registered read data one cycle after each request. After every reset it runs a clearing sweep and holds `ready` low until the array is zeroed. It sits between the core and the simulation top, replacing the external virtual RAM for local bring-up.

## Interface
- `BASE_ADDR`, default 64'h0000_0000_8000_0000: byte address mapped to array word 0.
- `DEPTH_LOG2`, default 12: log2 of the array depth in 64-bit words (4096 words, 32 KiB).
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous reset, active-high.
- `RamReadEnable  in  1`: read request this cycle.
- `RamReadAddr  in  64`: read byte address; bits [2:0] ignored.
- `RamReadData  out  64`: read data, registered.
- `RamWriteEnable  in  1`: write request this cycle.
- `RamWriteAddr  in  64`: write byte address; bits [2:0] ignored.
- `RamWriteMask  in  64`: per-bit write mask; 1 = bit written.
- `RamWriteData  in  64`: write data.
- `ready  out  1`: clearing sweep done; requests are serviced.
- `err  out  1`: sticky flag; an out-of-range request was seen while `ready` was high.

## Operation
- Word index = (addr − BASE_ADDR) >> 3, taken as unsigned 64-bit subtraction. The address is in range when the index is < 2^DEPTH_LOG2. An address below BASE_ADDR wraps to a large index and is therefore out of range.
- State machine has two states: CLEAR and RUN.
- **CLEAR** (entered on reset):
  - A DEPTH_LOG2-bit counter writes 0 to word[counter] each cycle, counting 0 up to 2^DEPTH_LOG2−1.
  - After the last word is written, the block moves to RUN and `ready` goes to 1.
  - While in CLEAR, write requests are ignored and `RamReadData` is driven as 0.
- **RUN**:
  - Write: when `RamWriteEnable` is 1 and the address is in range, word ← (word & ~RamWriteMask) | (RamWriteData & RamWriteMask) at the clock edge.
  - Read: when `RamReadEnable` is 1 and the address is in range, `RamReadData` ← word at the clock edge.
  - Read with `RamReadEnable` 0: `RamReadData` holds its previous value.
  - Out-of-range read: `RamReadData` ← 0 and `err` ← 1.
  - Out-of-range write: the array is unchanged and `err` ← 1.
  - `err` clears only on reset.
- Simultaneous read and write to the same word: result depends on `RAM_FWD_EN` (see Configuration).
- Simultaneous read and write to different words: both complete in the same cycle.

## Timing
- Reset values: `RamReadData` = 0, `ready` = 0, `err` = 0, state = CLEAR, counter = 0. Array contents are not reset directly; the sweep zeroes them.
- Reset asserted mid-sweep or in RUN: immediate return to CLEAR with counter = 0. The sweep restarts from word 0.
- After reset deasserts, `ready` rises 2^DEPTH_LOG2 rising edges later (4096 with default parameters).
- Read latency: 1 cycle. A request at edge N gives data valid after edge N, stable until the next read edge.
- Write latency: the write is visible to a read issued on the following cycle.
- Fully pipelined: one read plus one write accepted per cycle, with no back-pressure.

## Configuration
- `RAM_FWD_EN` defined: a read and write to the same in-range word in the same cycle return the merged value, (old & ~RamWriteMask) | (RamWriteData & RamWriteMask).
- `RAM_FWD_EN` undefined: the same case returns the old word contents. The write still commits.

## Test plan
- **Reset sweep:** assert `rst` for 3 cycles, then release. `ready` = 0 for 4096 edges, then 1. A read of 0x8000_0000 returns 0; `err` = 0.
- **Full write/read:** in RUN, write 0x8000_0010, data 0x1122334455667788, mask all ones. Read the same address next cycle; `RamReadData` = 0x1122334455667788 one cycle after the read.
- **Masked write:** write 0x8000_0010, data 0xFFFF_FFFF_FFFF_FFFF, mask 0x0000_0000_FFFF_0000. The read returns 0x11223344FFFF7788.
- **Same-cycle read and write:** word holds 0xA, write 0xB with mask all ones, read the same address in the same cycle. Returns 0xB with `RAM_FWD_EN` defined, 0xA without it. A read on the next cycle returns 0xB in both builds.
- **Out of range:** read 0x7FFF_FFF8, then write 0x8000_8000. `RamReadData` = 0, `err` = 1 and stays 1. Word 0 and word 4095 are unchanged.
- **Reset mid-sweep:** assert `rst` at sweep cycle 2000. `ready` stays 0 for a full 4096 edges after release. Data written before the reset reads back as 0.
